// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared constants and queue entry layout for instruction fetch
// Contents:
//   PC_W, INST_W         - fetch PC width and instruction word width
//   MEM_WORDS, RESET_PC  - default ROM size (words) and post-reset fetch PC
//   fetch_entry_t        - prefetch queue entry {pc, inst}, also seen by decode
package fetch_controller_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0] MEM_WORDS = 64'd64;
    localparam logic [PC_W-1:0] RESET_PC  = 64'd0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry synchronous prefetch FIFO with flush
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   push, din          - write din at the write pointer
//   pop                - advance the read pointer
//   flush              - empty the queue; overrides push and pop
//   dout               - head entry (storage register, no bypass)
//   full, count        - occupancy status, count in 0..DEPTH
module fetch_queue
    import fetch_controller_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic          full,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout = mem[rd_ptr];
    assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with prefetch queue, redirect and halt
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   imem_addr / imem_data        - ROM word address (= fetch PC) and combinational read data
//   redirect_valid, redirect_pc  - flush queue and restart fetch at redirect_pc
//   inst_valid/inst_ready        - handshake toward decode
//   inst_out, inst_pc            - head-of-queue instruction and its PC
//   halted                       - fetch PC is outside the ROM
module fetch_controller #(
    parameter int          DEPTH     = 2,
    parameter logic [63:0] MEM_WORDS = fetch_controller_pkg::MEM_WORDS,
    parameter logic [63:0] RESET_PC  = fetch_controller_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [63:0]                       fetch_pc;
    logic [63:0]                       pc_next;
    logic                              push;
    logic                              pop;
    logic                              q_full;
    logic [CW-1:0]                     q_count;
    fetch_controller_pkg::fetch_entry_t q_din;
    fetch_controller_pkg::fetch_entry_t q_dout;

    assign pop  = inst_valid && inst_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = !redirect_valid && !halted && (!q_full || pop);

    always_comb begin
        pc_next = fetch_pc;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (push) begin
            pc_next = fetch_pc + 64'd1;
        end
    end

    // halted tracks the registered PC, so a redirect both sets and clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else begin
            fetch_pc <= pc_next;
            halted   <= (pc_next >= MEM_WORDS);
        end
    end

    assign q_din = '{pc: fetch_pc, inst: imem_data};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .din     (q_din),
        .dout    (q_dout),
        .full    (q_full),
        .count   (q_count)
    );

    assign imem_addr  = fetch_pc;
    assign inst_valid = (q_count != '0);
    assign inst_out   = q_dout.inst;
    assign inst_pc    = q_dout.pc;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        if (a == 64'd1) return 32'h00702083;
        return 32'h1300_0000 | {16'h0, a[15:0]};
    endfunction

    assign imem_data = rom_word(imem_addr);

    fetch_controller dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst_pc !== 64'd0 || inst_out !== 32'd0) begin n_bad++; $display("FAIL rst_head: got pc=%0d inst=%h want 0/0", inst_pc, inst_out); end
        step();
        reset_n    = 1'b1;
        inst_ready = 1'b1;
        step(); step(); step();
        n_cmp++; if (imem_addr !== 64'd3) begin n_bad++; $display("FAIL pre_rst_addr: got %0d want 3", imem_addr); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL async_rst_halted: got %b want 0", halted); end
        n_cmp++; if (imem_addr !== 64'd0) begin n_bad++; $display("FAIL async_rst_addr: got %0d want 0", imem_addr); end
        n_cmp++; if (inst_pc !== 64'd0 || inst_out !== 32'd0) begin n_bad++; $display("FAIL async_rst_head: got pc=%0d inst=%h want 0/0", inst_pc, inst_out); end
    endtask

    task automatic test_streaming();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_pc !== 64'(k) || inst_out !== rom_word(64'(k))) begin
                n_bad++;
                $display("FAIL stream_%0d: got v=%b pc=%0d inst=%h want v=1 pc=%0d inst=%h", k, inst_valid, inst_pc, inst_out, k, rom_word(64'(k)));
            end
        end
        n_cmp++; if (rom_word(64'd1) !== 32'h00702083) begin n_bad++; $display("FAIL rom_pc1: got %h want 00702083", rom_word(64'd1)); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (dut.q_count !== 2'd2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", dut.q_count); end
        n_cmp++; if (imem_addr !== 64'd2) begin n_bad++; $display("FAIL bp_addr: got %0d want 2", imem_addr); end
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_pc !== 64'(k) || inst_out !== rom_word(64'(k))) begin
                n_bad++;
                $display("FAIL bp_drain_%0d: got v=%b pc=%0d want v=1 pc=%0d", k, inst_valid, inst_pc, k);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        inst_ready = 1'b0;
        step();
        n_cmp++; if (inst_pc !== 64'd3 || dut.q_count !== 2'd2) begin n_bad++; $display("FAIL redir_pre: got pc=%0d cnt=%0d want pc=3 cnt=2", inst_pc, dut.q_count); end
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'd10;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || imem_addr !== 64'd10) begin n_bad++; $display("FAIL redir_flush: got v=%b addr=%0d want v=0 addr=10", inst_valid, imem_addr); end
        for (int k = 10; k < 12; k++) begin
            step();
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_pc !== 64'(k) || inst_out !== rom_word(64'(k))) begin
                n_bad++;
                $display("FAIL redir_pc_%0d: got v=%b pc=%0d want v=1 pc=%0d", k, inst_valid, inst_pc, k);
            end
        end
    endtask

    task automatic test_halt_restart();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step();
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_pc !== 64'(k)) begin
                n_bad++;
                $display("FAIL run_pc_%0d: got v=%b pc=%0d want v=1 pc=%0d", k, inst_valid, inst_pc, k);
            end
        end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_set: got %b want 1", halted); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (inst_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 64'd64) begin
                n_bad++;
                $display("FAIL halt_hold_%0d: got v=%b h=%b addr=%0d want v=0 h=1 addr=64", k, inst_valid, halted, imem_addr);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'd13;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (halted !== 1'b0 || imem_addr !== 64'd13) begin n_bad++; $display("FAIL restart: got h=%b addr=%0d want h=0 addr=13", halted, imem_addr); end
        step();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 64'd13 || inst_out !== rom_word(64'd13)) begin n_bad++; $display("FAIL restart_pc: got v=%b pc=%0d want v=1 pc=13", inst_valid, inst_pc); end
    endtask

    task automatic test_out_of_range();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'd100;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 64'd100) begin n_bad++; $display("FAIL oor: got h=%b v=%b addr=%0d want h=1 v=0 addr=100", halted, inst_valid, imem_addr); end
        step(); step();
        n_cmp++; if (inst_valid !== 1'b0 || dut.q_count !== 2'd0 || imem_addr !== 64'd100) begin n_bad++; $display("FAIL oor_hold: got v=%b cnt=%0d addr=%0d want v=0 cnt=0 addr=100", inst_valid, dut.q_count, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_halt_restart();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Instruction-fetch sequencer in front of the combinational instruction ROM.
- Owns the fetch PC and drives the ROM word address; the ROM returns the instruction in the same cycle.
- Buffers fetched words in a small prefetch queue with a valid/ready handshake toward decode.
- Handles redirects (branch/jump/jalr) by flushing and reloading the PC, and halts fetch when the PC leaves the ROM range.

Parameters:
- DEPTH, 2, prefetch queue entries; power of 2, >= 2.
- MEM_WORDS, 64, number of valid ROM words; PC values >= MEM_WORDS are out of range.
- RESET_PC, 0, fetch PC after reset, in word units.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- imem_addr  out  64  word address to instruction ROM; always equals fetch_pc.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  64  redirect target, in word units.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_out  out  32  instruction at queue head.
- inst_pc  out  64  PC of the instruction at queue head.
- halted  out  1  fetch stopped because fetch_pc >= MEM_WORDS.

Behaviour:
- Reset (reset_n low, asynchronous) forces the following state:
  - fetch_pc = RESET_PC and queue count = 0.
  - Read and write pointers = 0.
  - halted = 0 and inst_valid = 0.
  - inst_out and inst_pc = 0.
- Outputs:
  - inst_out and inst_pc come from the head entry, registered.
  - inst_valid = (count != 0).
  - halted = (fetch_pc >= MEM_WORDS), registered with fetch_pc.
- pop = inst_valid && inst_ready.
- push = !redirect_valid && !halted && (count < DEPTH || pop).
  - On push, entry {fetch_pc, imem_data} is written at the write pointer and fetch_pc <= fetch_pc + 1.
  - fetch_pc holds when there is no push.
- Latency:
  - Queue empty: instruction at fetch_pc is presented on inst_* in the cycle after the push edge.
  - Sustained throughput with inst_ready high: one instruction per cycle.
- Full queue with a pop in the same cycle: push and pop both occur, count unchanged.
- Full queue with no pop: no push and the PC stalls. The ROM is re-read the next cycle, which is harmless.
- Redirect (redirect_valid=1) has the highest priority:
  - At the edge: queue flushed (count, read and write pointers = 0), fetch_pc <= redirect_pc, no push.
  - A simultaneous pop is discarded: decode must not commit it. Decode treats a redirect cycle as a kill.
  - halted recomputes from the new PC, so a redirect clears halt if redirect_pc < MEM_WORDS.
  - An out-of-range redirect_pc sets halted the next cycle, with the queue empty.
- Halt:
  - When fetch_pc reaches MEM_WORDS, no further pushes occur.
  - Queued entries still drain normally, and the last delivered PC is MEM_WORDS-1.
  - Only a redirect or reset leaves halt.
- Queue pointers wrap modulo DEPTH. count ranges over 0..DEPTH and has width clog2(DEPTH)+1.
- fetch_pc arithmetic is 64-bit unsigned with natural wrap; halt prevents reaching the wrap in normal use.
- Instruction word 0 is an ordinary nop: no decoding happens here and it is queued like any word.

Decomposition:
- Shared package/header:
  - constants MEM_WORDS and RESET_PC.
  - PC width (64) and instruction width (32).
  - the queue entry layout {pc[63:0], inst[31:0]}, shared with the decode stage.
- Sub-module fetch_queue: a synchronous DEPTH-entry FIFO.
  - Interfaces: push/pop/flush, full/empty/count, async active-low reset.
  - fetch_controller keeps the PC, halt and redirect logic.

Test Plan:
- Reset mid-stream: drop reset_n between clock edges → inst_valid=0, halted=0 and imem_addr=0 immediately, with no clk edge required.
- Streaming: inst_ready=1 after reset → inst_pc 0,1,2,3 on consecutive cycles, and inst_out matches the ROM words (PC 1 → 32'h00702083).
- Backpressure: inst_ready=0 for 5 cycles → count saturates at 2 (PCs 0,1) and imem_addr holds at 2. On release, PCs 0,1,2,3 arrive in order with no gap or duplicate.
- Redirect with queue holding PCs 3,4 plus a same-cycle pop: redirect_valid=1, redirect_pc=10 → next valid inst_pc=10 then 11; PCs 3 and 4 are never presented again.
- Halt and restart:
  - Run to the end → last delivered inst_pc=63, then halted=1 and inst_valid=0 after drain, with imem_addr=64 stable.
  - Redirect to 13 → halted=0 and inst_pc=13 is delivered.
- Out-of-range redirect: redirect_pc=100 → halted=1 the next cycle, queue empty, no pushes.
